bp_update_arbiter: RTL

Collects resolved-branch training updates from two branch execution units, buffers them in a small FIFO, and feeds the tournament predictor's single update port at most one record per cycle. It sits between the branch units and the predictor inside the instruction-queue subsystem. It also keeps wrapping branch and misprediction counters for performance monitoring.

---
 rtl/bp_update_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bp_update_arbiter.sv
// rtl/bp_update_arbiter.sv - merges two branch-unit training streams into one predictor update port
// Small FIFO with priority-rotating dual enqueue, one issue per cycle, wrapping perf counters.
module bp_update_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [16:0]      a_addr,
  input  logic             a_take,
  input  logic             a_miss,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [16:0]      b_addr,
  input  logic             b_take,
  input  logic             b_miss,
  output logic             rec_en,
  output logic [16:0]      rec_addr,
  output logic             rec_take,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE_FREE = CW'(DEPTH - 1);

  logic [18:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          prio;
  logic          rec_miss;

  logic          a_hs;
  logic          b_hs;
  logic          pop;
  logic [1:0]    n_push;
  logic [18:0]   a_ent;
  logic [18:0]   b_ent;
  logic [18:0]   first_ent;
  logic [18:0]   second_ent;

  // Ready looks only at registered state so it never sees a same-cycle pop.
  always_comb begin
    a_ready = (count < ONE_FREE) || ((count == ONE_FREE) && !prio);
    b_ready = (count < ONE_FREE) || ((count == ONE_FREE) && prio);
  end

  always_comb begin
    a_hs       = a_valid && a_ready && !flush;
    b_hs       = b_valid && b_ready && !flush;
    pop        = (count != '0) && !flush;
    n_push     = {1'b0, a_hs} + {1'b0, b_hs};
    a_ent      = {a_addr, a_take, a_miss};
    b_ent      = {b_addr, b_take, b_miss};
    first_ent  = (b_hs && (!a_hs || prio)) ? b_ent : a_ent;
    second_ent = prio ? a_ent : b_ent;
  end

  // Storage is deliberately left unreset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (a_hs || b_hs) begin
      mem[wr_ptr] <= first_ent;
    end
    if (a_hs && b_hs) begin
      mem[wr_ptr + PW'(1)] <= second_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      prio     <= 1'b0;
      rec_en   <= 1'b0;
      rec_addr <= '0;
      rec_take <= 1'b0;
      rec_miss <= 1'b0;
    end else begin
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        rec_en <= 1'b0;
      end else begin
        count  <= count + CW'(n_push) - CW'(pop);
        wr_ptr <= wr_ptr + PW'(n_push);
        rd_ptr <= rd_ptr + PW'(pop);
        rec_en <= pop;
        if (pop) begin
          {rec_addr, rec_take, rec_miss} <= mem[rd_ptr];
        end
      end
      if (a_hs && b_hs) begin
        prio <= !prio;
      end else if (a_hs) begin
        prio <= 1'b1;
      end else if (b_hs) begin
        prio <= 1'b0;
      end
    end
  end

  // Counters see the strobe as registered, so a record already out during flush still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (rec_en) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (rec_en && rec_miss) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule
